// File: rtl/id_ex_stage_register_pkg.sv
// rtl/id_ex_stage_register_pkg.sv - shared widths, ID/EX bundle types and bubble constant
package id_ex_stage_register_pkg;

    localparam int DATA_W  = 32;
    localparam int REG_W   = 5;
    localparam int ALUOP_W = 4;

    typedef struct packed {
        logic               reg_write;
        logic               mem_read;
        logic               mem_write;
        logic               mem_to_reg;
        logic               alu_src;
        logic               reg_dst;
        logic [ALUOP_W-1:0] alu_op;
    } ctrl_t;

    typedef struct packed {
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] reg_data1;
        logic [DATA_W-1:0] reg_data2;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] pc_next;
        ctrl_t             ctrl;
    } stage_t;

    // All-zero bundle: no writes, no memory access, specifiers never match forwarding.
    localparam stage_t BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_register_hazard_detect.sv
// rtl/id_ex_stage_register_hazard_detect.sv - combinational load-use hazard and stall equation
module id_ex_stage_register_hazard_detect
    import id_ex_stage_register_pkg::*;
(
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             enable,
    input  logic             flush,
    output logic             hazard,
    output logic             stall
);

    // A load targeting $0 never produces a value worth waiting for.
    assign hazard = ex_mem_read && (ex_rt != '0) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    assign stall = hazard && enable && !flush;

endmodule

// File: rtl/id_ex_stage_register.sv
// rtl/id_ex_stage_register.sv - ID/EX pipeline register with load-use bubble insertion
module id_ex_stage_register
    import id_ex_stage_register_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic               I_IDEX_clk,
    input  logic               I_IDEX_reset_n,
    input  logic               I_IDEX_enable,
    input  logic               I_IDEX_flush,
    input  logic [REG_W-1:0]   I_IDEX_RS,
    input  logic [REG_W-1:0]   I_IDEX_RT,
    input  logic [REG_W-1:0]   I_IDEX_RD,
    input  logic               I_IDEX_usesRT,
    input  logic [DATA_W-1:0]  I_IDEX_regData1,
    input  logic [DATA_W-1:0]  I_IDEX_regData2,
    input  logic [DATA_W-1:0]  I_IDEX_imm,
    input  logic [DATA_W-1:0]  I_IDEX_pcNext,
    input  logic               I_IDEX_RegWrite,
    input  logic               I_IDEX_MemRead,
    input  logic               I_IDEX_MemWrite,
    input  logic               I_IDEX_MemtoReg,
    input  logic               I_IDEX_ALUSrc,
    input  logic               I_IDEX_RegDst,
    input  logic [ALUOP_W-1:0] I_IDEX_ALUOp,
    output logic [REG_W-1:0]   O_IDEX_RS,
    output logic [REG_W-1:0]   O_IDEX_RT,
    output logic [REG_W-1:0]   O_IDEX_RD,
    output logic [DATA_W-1:0]  O_IDEX_regData1,
    output logic [DATA_W-1:0]  O_IDEX_regData2,
    output logic [DATA_W-1:0]  O_IDEX_imm,
    output logic [DATA_W-1:0]  O_IDEX_pcNext,
    output logic               O_IDEX_RegWrite,
    output logic               O_IDEX_MemRead,
    output logic               O_IDEX_MemWrite,
    output logic               O_IDEX_MemtoReg,
    output logic               O_IDEX_ALUSrc,
    output logic               O_IDEX_RegDst,
    output logic [ALUOP_W-1:0] O_IDEX_ALUOp,
    output logic               O_IDEX_stall,
    output logic [CNT_W-1:0]   O_IDEX_bubbleCount
);

    stage_t           id_d;
    stage_t           ex_q;
    logic             hazard;
    logic [CNT_W-1:0] bubble_count;

    assign id_d = '{
        rs:        I_IDEX_RS,
        rt:        I_IDEX_RT,
        rd:        I_IDEX_RD,
        reg_data1: I_IDEX_regData1,
        reg_data2: I_IDEX_regData2,
        imm:       I_IDEX_imm,
        pc_next:   I_IDEX_pcNext,
        ctrl:      '{
            reg_write:  I_IDEX_RegWrite,
            mem_read:   I_IDEX_MemRead,
            mem_write:  I_IDEX_MemWrite,
            mem_to_reg: I_IDEX_MemtoReg,
            alu_src:    I_IDEX_ALUSrc,
            reg_dst:    I_IDEX_RegDst,
            alu_op:     I_IDEX_ALUOp
        }
    };

    id_ex_stage_register_hazard_detect u_hazard_detect (
        .ex_mem_read (ex_q.ctrl.mem_read),
        .ex_rt       (ex_q.rt),
        .id_rs       (I_IDEX_RS),
        .id_rt       (I_IDEX_RT),
        .id_uses_rt  (I_IDEX_usesRT),
        .enable      (I_IDEX_enable),
        .flush       (I_IDEX_flush),
        .hazard      (hazard),
        .stall       (O_IDEX_stall)
    );

    // Flush outranks the hazard so a squashed instruction is never counted as a stall.
    always_ff @(posedge I_IDEX_clk or negedge I_IDEX_reset_n) begin
        if (!I_IDEX_reset_n) begin
            ex_q         <= BUBBLE;
            bubble_count <= '0;
        end else if (I_IDEX_enable) begin
            if (I_IDEX_flush) begin
                ex_q <= BUBBLE;
            end else if (hazard) begin
                ex_q <= BUBBLE;
                if (bubble_count != '1)
                    bubble_count <= bubble_count + CNT_W'(1);
            end else begin
                ex_q <= id_d;
            end
        end
    end

    assign O_IDEX_RS          = ex_q.rs;
    assign O_IDEX_RT          = ex_q.rt;
    assign O_IDEX_RD          = ex_q.rd;
    assign O_IDEX_regData1    = ex_q.reg_data1;
    assign O_IDEX_regData2    = ex_q.reg_data2;
    assign O_IDEX_imm         = ex_q.imm;
    assign O_IDEX_pcNext      = ex_q.pc_next;
    assign O_IDEX_RegWrite    = ex_q.ctrl.reg_write;
    assign O_IDEX_MemRead     = ex_q.ctrl.mem_read;
    assign O_IDEX_MemWrite    = ex_q.ctrl.mem_write;
    assign O_IDEX_MemtoReg    = ex_q.ctrl.mem_to_reg;
    assign O_IDEX_ALUSrc      = ex_q.ctrl.alu_src;
    assign O_IDEX_RegDst      = ex_q.ctrl.reg_dst;
    assign O_IDEX_ALUOp       = ex_q.ctrl.alu_op;
    assign O_IDEX_bubbleCount = bubble_count;

endmodule

// File: tb/tb_id_ex_stage_register.sv
// tb/tb_id_ex_stage_register.sv - scoreboard bench for the ID/EX register and load-use stall
module tb_id_ex_stage_register;

    localparam int CW = 8;

    typedef struct packed {
        logic [4:0]  rs, rt, rd;
        logic [31:0] d1, d2, imm, pc;
        logic        rw, mr, mw, m2r, as, rdst;
        logic [3:0]  aluop;
    } out_t;

    typedef struct packed {
        out_t o;
        logic uses_rt;
    } id_in_t;

    typedef struct packed {
        out_t          o;
        logic [CW-1:0] cnt;
        logic          stall;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        fl = 1'b0;
    id_in_t      din = '0;
    out_t        dout;
    logic        stall;
    logic [CW-1:0] cnt;

    exp_t sb[$];
    out_t m_ex = '0;
    logic [CW-1:0] m_cnt = '0;
    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    id_ex_stage_register #(.CNT_W(CW)) dut (
        .I_IDEX_clk         (clk),
        .I_IDEX_reset_n     (rst_n),
        .I_IDEX_enable      (en),
        .I_IDEX_flush       (fl),
        .I_IDEX_RS          (din.o.rs),
        .I_IDEX_RT          (din.o.rt),
        .I_IDEX_RD          (din.o.rd),
        .I_IDEX_usesRT      (din.uses_rt),
        .I_IDEX_regData1    (din.o.d1),
        .I_IDEX_regData2    (din.o.d2),
        .I_IDEX_imm         (din.o.imm),
        .I_IDEX_pcNext      (din.o.pc),
        .I_IDEX_RegWrite    (din.o.rw),
        .I_IDEX_MemRead     (din.o.mr),
        .I_IDEX_MemWrite    (din.o.mw),
        .I_IDEX_MemtoReg    (din.o.m2r),
        .I_IDEX_ALUSrc      (din.o.as),
        .I_IDEX_RegDst      (din.o.rdst),
        .I_IDEX_ALUOp       (din.o.aluop),
        .O_IDEX_RS          (dout.rs),
        .O_IDEX_RT          (dout.rt),
        .O_IDEX_RD          (dout.rd),
        .O_IDEX_regData1    (dout.d1),
        .O_IDEX_regData2    (dout.d2),
        .O_IDEX_imm         (dout.imm),
        .O_IDEX_pcNext      (dout.pc),
        .O_IDEX_RegWrite    (dout.rw),
        .O_IDEX_MemRead     (dout.mr),
        .O_IDEX_MemWrite    (dout.mw),
        .O_IDEX_MemtoReg    (dout.m2r),
        .O_IDEX_ALUSrc      (dout.as),
        .O_IDEX_RegDst      (dout.rdst),
        .O_IDEX_ALUOp       (dout.aluop),
        .O_IDEX_stall       (stall),
        .O_IDEX_bubbleCount (cnt)
    );

    task automatic check(input string name, input logic [159:0] got, input logic [159:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    function automatic id_in_t rand_in(input int reg_max);
        id_in_t r;
        r.o.rs    = 5'($urandom_range(0, reg_max));
        r.o.rt    = 5'($urandom_range(0, reg_max));
        r.o.rd    = 5'($urandom);
        r.o.d1    = $urandom;
        r.o.d2    = $urandom;
        r.o.imm   = $urandom;
        r.o.pc    = $urandom;
        r.o.rw    = 1'($urandom);
        r.o.mr    = 1'($urandom);
        r.o.mw    = 1'($urandom);
        r.o.m2r   = 1'($urandom);
        r.o.as    = 1'($urandom);
        r.o.rdst  = 1'($urandom);
        r.o.aluop = 4'($urandom);
        r.uses_rt = 1'($urandom);
        return r;
    endfunction

    function automatic id_in_t load_word(input logic [4:0] rt);
        id_in_t r = rand_in(31);
        r.o.rt = rt;
        r.o.rs = (rt == 5'd1) ? 5'd2 : 5'd1;
        r.o.mr = 1'b1;
        r.o.rw = 1'b1;
        return r;
    endfunction

    function automatic id_in_t user(input logic [4:0] rs, input logic [4:0] rt, input logic uses);
        id_in_t r = rand_in(31);
        r.o.rs    = rs;
        r.o.rt    = rt;
        r.uses_rt = uses;
        return r;
    endfunction

    // Reference: the EX copy is whatever ID held at the last enabled, non-squashed, non-hazard edge.
    task automatic cycle(input id_in_t in, input logic e, input logic f);
        logic hz;
        exp_t x;
        @(posedge clk);
        #2;
        din = in;
        en  = e;
        fl  = f;
        hz  = m_ex.mr && (m_ex.rt != 0) &&
              ((m_ex.rt == in.o.rs) || (in.uses_rt && (m_ex.rt == in.o.rt)));
        x.o     = m_ex;
        x.cnt   = m_cnt;
        x.stall = hz && e && !f;
        sb.push_back(x);
        if (e) begin
            if (f || hz) m_ex = '0;
            else         m_ex = in.o;
            if (hz && !f && m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
        end
    endtask

    always begin
        exp_t e;
        @(posedge clk);
        #4;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("outputs", 160'(dout), 160'(e.o));
            check("bubble_count", 160'(cnt), 160'(e.cnt));
            check("stall", 160'(stall), 160'(e.stall));
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #3;
        check("reset_outputs", 160'(dout), 160'(0));
        check("reset_count", 160'(cnt), 160'(0));
        #10 rst_n = 1'b1;

        // Load-use on RS, then the stalled instruction is re-presented and loads.
        cycle(load_word(5'd5), 1'b1, 1'b0);
        cycle(user(5'd5, 5'd9, 1'b0), 1'b1, 1'b0);
        cycle(user(5'd5, 5'd9, 1'b0), 1'b1, 1'b0);
        // Load-use on RT only when RT is a source.
        cycle(load_word(5'd7), 1'b1, 1'b0);
        cycle(user(5'd3, 5'd7, 1'b0), 1'b1, 1'b0);
        cycle(load_word(5'd7), 1'b1, 1'b0);
        cycle(user(5'd3, 5'd7, 1'b1), 1'b1, 1'b0);
        // Load to $0 never stalls.
        cycle(load_word(5'd0), 1'b1, 1'b0);
        cycle(user(5'd0, 5'd0, 1'b1), 1'b1, 1'b0);
        // Flush with simultaneous hazard.
        cycle(load_word(5'd4), 1'b1, 1'b0);
        cycle(user(5'd4, 5'd4, 1'b1), 1'b1, 1'b1);
        // Enable low freezes state and masks stall.
        cycle(load_word(5'd6), 1'b1, 1'b0);
        cycle(user(5'd6, 5'd1, 1'b0), 1'b0, 1'b0);
        cycle(user(5'd6, 5'd1, 1'b0), 1'b0, 1'b0);
        cycle(user(5'd6, 5'd1, 1'b0), 1'b1, 1'b0);
        cycle(user(5'd6, 5'd1, 1'b0), 1'b1, 1'b0);

        for (int i = 0; i < 300; i++)
            cycle(rand_in(3), ($urandom_range(0, 9) != 0), ($urandom_range(0, 9) == 0));

        // Asynchronous reset between edges, mid-stream.
        cycle(load_word(5'd2), 1'b1, 1'b0);
        cycle(user(5'd2, 5'd2, 1'b1), 1'b1, 1'b0);
        @(posedge clk);
        #6;
        rst_n = 1'b0;
        en    = 1'b0;
        #1;
        check("async_reset_outputs", 160'(dout), 160'(0));
        check("async_reset_count", 160'(cnt), 160'(0));
        m_ex  = '0;
        m_cnt = '0;
        #1 rst_n = 1'b1;

        // Drive the counter past its saturation point.
        for (int i = 0; i < (1 << CW) + 3; i++) begin
            cycle(load_word(5'd5), 1'b1, 1'b0);
            cycle(user(5'd5, 5'd0, 1'b0), 1'b1, 1'b0);
        end
        cycle(user(5'd8, 5'd8, 1'b1), 1'b1, 1'b0);

        repeat (2) @(posedge clk);
        #6;
        check("scoreboard_drained", 160'(sb.size()), 160'(0));
        check("final_count_saturated", 160'(cnt), 160'({CW{1'b1}}));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_stage_register.md
# id_ex_stage_register

ID/EX pipeline register with integrated load-use hazard detection for the 5-stage MIPS core. Captures decoded operands, register specifiers and control bits from ID each cycle and presents them to EX, where its RS/RT/regDst outputs feed the forwarding unit. Detects a load in EX whose destination is read by the instruction in ID. On that hazard it stalls PC and IF/ID and inserts a bubble. Also honours branch flush and the debug-unit step enable.

## Interface
- DATA_W, 32, operand/immediate/PC width
- REG_W, 5, register specifier width
- ALUOP_W, 4, ALU control width
- CNT_W, 16, bubble counter width
- I_IDEX_clk  in  1  clock, rising edge
- I_IDEX_reset_n  in  1  reset, asynchronous, active-low
- I_IDEX_enable  in  1  pipeline advance enable (debug step / run)
- I_IDEX_flush  in  1  branch taken in EX: squash instruction in ID
- I_IDEX_RS, I_IDEX_RT, I_IDEX_RD  in  REG_W  ID register specifiers
- I_IDEX_usesRT  in  1  ID instruction reads RT as a source
- I_IDEX_regData1, I_IDEX_regData2, I_IDEX_imm, I_IDEX_pcNext  in  DATA_W  ID operands
- I_IDEX_RegWrite, I_IDEX_MemRead, I_IDEX_MemWrite, I_IDEX_MemtoReg, I_IDEX_ALUSrc, I_IDEX_RegDst  in  1  ID control
- I_IDEX_ALUOp  in  ALUOP_W  ID ALU control
- O_IDEX_* (same names as every data/specifier/control input, usesRT excluded)  out  same width  registered EX-stage copies
- O_IDEX_stall  out  1  hold PC and IF/ID this cycle
- O_IDEX_bubbleCount  out  CNT_W  saturating count of inserted load-use bubbles

## Operation
- Hazard (combinational): hazard = O_IDEX_MemRead && O_IDEX_RT != 0 && (O_IDEX_RT == I_IDEX_RS || (I_IDEX_usesRT && O_IDEX_RT == I_IDEX_RT)).
- O_IDEX_stall = hazard && I_IDEX_enable && !I_IDEX_flush.
- Per-edge update, priority order:
  1. reset low: all outputs 0, counter 0.
  2. !enable: all registers hold; counter holds.
  3. flush: load bubble.
  4. hazard: load bubble; counter += 1, saturating at all-ones.
  5. otherwise: load all ID inputs.
- Bubble = every O_IDEX_* register 0. RegWrite/MemRead/MemWrite = 0 guarantees no architectural effect. RS/RT = 0 guarantees the forwarding unit never matches.
- Flush with a simultaneous hazard: flush wins, no counter increment, stall low.
- A stalled ID instruction is re-presented unchanged next cycle. The bubble's MemRead = 0 clears the hazard, so a stall is always exactly one cycle per load-use pair.
- Load writing $0: no hazard, no stall.

## Timing
- Latency: ID inputs appear on outputs 1 cycle after the enabled edge.
- O_IDEX_stall is combinational, valid same cycle, and is sampled by the PC and IF/ID registers at the same edge that loads the bubble.
- Reset assertion takes effect immediately, mid-stall or otherwise. The first edge after deassertion behaves as a normal load.
- enable low freezes stall-causing state; stall output stays low while enable is low.

## Structure
- Shared package: REG_W, DATA_W, ALUOP_W, the control-bundle struct, and the BUBBLE constant (all-zero bundle).
- One sub-module: hazard_detect (pure combinational hazard/stall equation). The register and counter stay in the top module.

## Test plan
- Reset mid-stream: drive non-zero inputs, pull reset low between edges -> all outputs 0 immediately, counter 0.
- Load-use on RS: EX holds lw with RT=5, MemRead=1; ID RS=5 -> stall=1 that cycle; next edge outputs all 0, count=1; following edge the ID instruction loads, stall=0.
- RT not used: EX lw RT=7; ID RT=7, usesRT=0, RS=3 -> stall=0, normal load, count unchanged.
- Load to $0: EX lw RT=0, ID RS=0 -> stall=0.
- Flush plus hazard in the same cycle -> stall=0, bubble loaded, count unchanged. With enable=0 and hazard present -> stall=0, outputs unchanged across edges.
- Saturation: force 2^CNT_W-1 hazards, then one more -> count stays 0xFFFF (CNT_W=16).
